// File: rtl/alu_pkg.sv
// Shared op codes, op-group selectors and sequencer states for the bit-serial ALU path.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_SHR = 4'b1000;
    localparam logic [3:0] OP_SHL = 4'b1100;

    // Group codes decoded from op[3:2].
    localparam logic [1:0] SEL_ARITH = 2'b00;
    localparam logic [1:0] SEL_LOGIC = 2'b01;
    localparam logic [1:0] SEL_SHR   = 2'b10;
    localparam logic [1:0] SEL_SHL   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/bitserial_alu_seq.sv
// Drives a 1-bit ALU slice LSB-first over WIDTH cycles and gathers its f bits into a result.
// Latency: accept edge N -> done_o in cycle N+WIDTH+1; start_i is ignored unless ready_o.
module bitserial_alu_seq
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       op_i,
    input  logic             cin_i,
    output logic             slice_a_o,
    output logic             slice_b_o,
    output logic             slice_cin_o,
    output logic [3:0]       slice_sel_o,
    input  logic             slice_f_i,
    input  logic             slice_cout_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             cout_o
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_e           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_result;
    logic [3:0]       r_op;
    logic [CNT_W-1:0] r_idx;
    logic             r_carry;
    logic             r_prev;
    logic             r_a0;
    logic             r_cout;
    logic             r_done;
    logic             r_ready;
    logic             r_busy;

    logic             w_last;
    logic             w_bit;
    logic             w_cout_fin;
    logic [WIDTH-1:0] w_acc_nxt;

    assign w_last    = (r_idx == LAST_IDX);
    assign w_acc_nxt = {w_bit, r_acc[WIDTH-1:1]};

    // Shifts bypass the slice: SHR takes the next A bit, SHL takes the previous one.
    always_comb begin
        w_bit = slice_f_i;
        unique case (r_op[3:2])
            SEL_SHR: w_bit = w_last ? 1'b0 : r_a_sh[1];
            SEL_SHL: w_bit = r_prev;
            default: w_bit = slice_f_i;
        endcase
    end

    // Evaluated on the last RUN cycle, where r_a_sh[0] is the original A MSB.
    always_comb begin
        w_cout_fin = 1'b0;
        unique case (r_op[3:2])
            SEL_ARITH: w_cout_fin = slice_cout_i;
            SEL_SHR:   w_cout_fin = r_a0;
            SEL_SHL:   w_cout_fin = r_a_sh[0];
            default:   w_cout_fin = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= IDLE;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_op     <= '0;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_prev   <= 1'b0;
            r_a0     <= 1'b0;
            r_cout   <= 1'b0;
            r_done   <= 1'b0;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_a_sh  <= a_i;
                        r_b_sh  <= b_i;
                        r_op    <= op_i;
                        r_carry <= cin_i;
                        r_a0    <= a_i[0];
                        r_idx   <= '0;
                        r_prev  <= 1'b0;
                        r_acc   <= '0;
                        r_state <= RUN;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                RUN: begin
                    r_acc   <= w_acc_nxt;
                    r_a_sh  <= r_a_sh >> 1;
                    r_b_sh  <= r_b_sh >> 1;
                    r_prev  <= r_a_sh[0];
                    r_carry <= slice_cout_i;
                    if (w_last) begin
                        r_result <= w_acc_nxt;
                        r_cout   <= w_cout_fin;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= DONE;
                    end else begin
                        r_idx <= r_idx + CNT_W'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign slice_a_o   = r_a_sh[0];
    assign slice_b_o   = r_b_sh[0];
    assign slice_cin_o = r_carry;
    assign slice_sel_o = r_op;
    assign ready_o     = r_ready;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign result_o    = r_result;
    assign cout_o      = r_cout;

endmodule

// File: tb/tb_bitserial_alu_seq.sv
// Directed bench for bitserial_alu_seq with a behavioural 1-bit slice closing the loop.
module tb_bitserial_alu_seq;
    import alu_pkg::*;

    localparam int WIDTH = 32;

    logic             clk_i   = 1'b0;
    logic             rst_ni  = 1'b0;
    logic             start_i = 1'b0;
    logic [WIDTH-1:0] a_i     = '0;
    logic [WIDTH-1:0] b_i     = '0;
    logic [3:0]       op_i    = '0;
    logic             cin_i   = 1'b0;
    logic             ready_o, busy_o, done_o, cout_o;
    logic             slice_a_o, slice_b_o, slice_cin_o;
    logic [3:0]       slice_sel_o;
    logic             slice_f, slice_cout;
    logic [WIDTH-1:0] result_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    // Reference slice: ADD = a+b+cin per bit, AND = a&b; anything else returns 0.
    always_comb begin
        slice_f    = 1'b0;
        slice_cout = 1'b0;
        case (slice_sel_o)
            OP_ADD: begin
                slice_f    = slice_a_o ^ slice_b_o ^ slice_cin_o;
                slice_cout = (slice_a_o & slice_b_o) | (slice_cin_o & (slice_a_o ^ slice_b_o));
            end
            OP_AND:  slice_f = slice_a_o & slice_b_o;
            default: slice_f = 1'b0;
        endcase
    end

    bitserial_alu_seq #(.WIDTH(WIDTH)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .ready_o      (ready_o),
        .a_i          (a_i),
        .b_i          (b_i),
        .op_i         (op_i),
        .cin_i        (cin_i),
        .slice_a_o    (slice_a_o),
        .slice_b_o    (slice_b_o),
        .slice_cin_o  (slice_cin_o),
        .slice_sel_o  (slice_sel_o),
        .slice_f_i    (slice_f),
        .slice_cout_i (slice_cout),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .result_o     (result_o),
        .cout_o       (cout_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Issues one op and waits for done_o. waits = edges spent waiting for ready_o,
    // edges = edges after the accept edge until done_o is seen (-1 on timeout),
    // busy_cnt = samples with busy_o high from the accept edge onward.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [3:0] op, input logic cin, input bit pulse,
                          output int waits, output int edges, output int busy_cnt);
        bit seen;
        waits = 0;
        start_i = 1'b1;
        a_i = a; b_i = b; op_i = op; cin_i = cin;
        while (!ready_o && waits < 8) begin
            @(posedge clk_i); #1;
            waits++;
        end
        @(posedge clk_i); #1;
        start_i  = 1'b0;
        busy_cnt = busy_o ? 1 : 0;
        edges    = 0;
        seen     = 1'b0;
        while (!seen && edges < WIDTH + 8) begin
            @(posedge clk_i); #1;
            edges++;
            if (busy_o) busy_cnt++;
            if (done_o) seen = 1'b1;
            if (pulse && edges == 4) begin
                start_i = 1'b1;
                a_i = ~a; b_i = 32'h0000_0005; op_i = OP_AND; cin_i = ~cin;
            end else begin
                start_i = 1'b0;
            end
        end
        if (!seen) edges = -1;
    endtask

    initial begin
        int w, e, bc, dones;

        // Reset held with start asserted: nothing may be accepted.
        rst_ni = 1'b0; start_i = 1'b1; a_i = '1; b_i = '1; op_i = OP_ADD; cin_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_ready",  64'(ready_o), 64'd1);
        chk("rst_busy",   64'(busy_o), 64'd0);
        chk("rst_done",   64'(done_o), 64'd0);
        chk("rst_result", 64'(result_o), 64'd0);
        chk("rst_cout",   64'(cout_o), 64'd0);
        chk("rst_slice",  64'({slice_a_o, slice_b_o, slice_cin_o, slice_sel_o}), 64'd0);
        @(negedge clk_i);
        start_i = 1'b0;
        rst_ni  = 1'b1;
        @(posedge clk_i); #1;
        chk("no_accept_after_release", 64'(busy_o), 64'd0);

        // ADD with full carry ripple: done_o WIDTH edges after accept edge (cycle N+WIDTH+1).
        run_op(32'hFFFF_FFFF, 32'h0000_0001, OP_ADD, 1'b0, 1'b0, w, e, bc);
        chk("add_latency",  64'(e), 64'(WIDTH));
        chk("add_busy_cyc", 64'(bc), 64'(WIDTH));
        chk("add_result",   64'(result_o), 64'h0000_0000);
        chk("add_cout",     64'(cout_o), 64'd1);
        @(posedge clk_i); #1;
        chk("done_one_cycle", 64'(done_o), 64'd0);
        chk("ready_after",    64'(ready_o), 64'd1);

        run_op(32'hF0F0_A5A5, 32'hFF00_FF00, OP_AND, 1'b1, 1'b0, w, e, bc);
        chk("and_result", 64'(result_o), 64'hF000_A500);
        chk("and_cout",   64'(cout_o), 64'd0);

        run_op(32'h8000_0001, 32'h0, OP_SHR, 1'b0, 1'b0, w, e, bc);
        chk("shr_result", 64'(result_o), 64'h4000_0000);
        chk("shr_cout",   64'(cout_o), 64'd1);

        run_op(32'h8000_0001, 32'h0, OP_SHL, 1'b0, 1'b0, w, e, bc);
        chk("shl_result", 64'(result_o), 64'h0000_0002);
        chk("shl_cout",   64'(cout_o), 64'd1);
        @(posedge clk_i); #1;
        chk("sel_hold_idle", 64'(slice_sel_o), 64'(OP_SHL));

        // Mid-RUN start pulse with other operands must not disturb the op in flight.
        run_op(32'h1234_5678, 32'h1111_1111, OP_ADD, 1'b1, 1'b1, w, e, bc);
        chk("pulse_latency", 64'(e), 64'(WIDTH));
        chk("pulse_result",  64'(result_o), 64'h2345_678A);
        chk("pulse_cout",    64'(cout_o), 64'd0);

        // Issued from the done_o cycle: accepted on the very next cycle.
        run_op(32'h8000_0000, 32'h8000_0000, OP_ADD, 1'b1, 1'b0, w, e, bc);
        chk("b2b_wait",   64'(w), 64'd1);
        chk("b2b_result", 64'(result_o), 64'h0000_0001);
        chk("b2b_cout",   64'(cout_o), 64'd1);
        repeat (5) @(posedge clk_i);
        #1;
        chk("result_held", 64'(result_o), 64'h0000_0001);

        // Abort an ADD at idx=10 with reset.
        @(negedge clk_i);
        start_i = 1'b1; a_i = 32'hFFFF_FFFF; b_i = 32'h1; op_i = OP_ADD; cin_i = 1'b0;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #1;
        chk("abort_busy_pre", 64'(busy_o), 64'd1);
        rst_ni = 1'b0;
        #1;
        chk("abort_ready",  64'(ready_o), 64'd1);
        chk("abort_busy",   64'(busy_o), 64'd0);
        chk("abort_result", 64'(result_o), 64'd0);
        chk("abort_cout",   64'(cout_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        dones = 0;
        repeat (WIDTH + 4) begin
            @(posedge clk_i); #1;
            if (done_o) dones++;
        end
        chk("abort_no_done", 64'(dones), 64'd0);

        run_op(32'h0000_FFFF, 32'h0000_0001, OP_ADD, 1'b0, 1'b0, w, e, bc);
        chk("post_abort_latency", 64'(e), 64'(WIDTH));
        chk("post_abort_result",  64'(result_o), 64'h0001_0000);
        chk("post_abort_cout",    64'(cout_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bitserial_alu_seq.md
Name: bitserial_alu_seq

Overview:
Bit-serial sequencer that sits directly upstream of the 1-bit ALU slice. It accepts a full WIDTH-bit operation, then drives the slice one bit per cycle, LSB first, over WIDTH cycles. Each cycle it carries cout back into the next cin and assembles the returned f bits into a WIDTH-bit result with a carry-out flag. It is the area-minimal datapath option alongside the parallel 32-bit ALU.

Parameters:
WIDTH, 32, operand/result width in bits; legal range 2..64.
CNT_W, $clog2(WIDTH), bit-index counter width (derived, not overridable).

Ports:
clk_i  input  1  clock; all state on rising edge.
rst_ni  input  1  asynchronous active-low reset.
start_i  input  1  request; accepted when start_i && ready_o.
ready_o  output  1  high only in IDLE.
a_i  input  WIDTH  operand A, sampled on accept.
b_i  input  WIDTH  operand B, sampled on accept.
op_i  input  4  slice select code, sampled on accept.
cin_i  input  1  initial carry, sampled on accept.
slice_a_o  output  1  current A bit to slice a_i.
slice_b_o  output  1  current B bit to slice b_i.
slice_cin_o  output  1  current carry to slice cin_i.
slice_sel_o  output  4  latched op to slice sel_i.
slice_f_i  input  1  slice f_o (combinational return).
slice_cout_i  input  1  slice cout_o.
busy_o  output  1  high in RUN.
done_o  output  1  one-cycle pulse when result_o/cout_o update.
result_o  output  WIDTH  result, held until next done_o.
cout_o  output  1  carry/shift-out flag, held with result_o.

Behaviour:
- Reset (async assert, sync release): state=IDLE, ready_o=1, busy_o=0, done_o=0, result_o=0, cout_o=0, all slice_*_o=0, and all internal registers cleared.
- FSM: IDLE -> RUN on accept. RUN -> DONE when idx==WIDTH-1. DONE -> IDLE unconditionally after 1 cycle.
- On accept: a_sh<=a_i, b_sh<=b_i, op_q<=op_i, carry<=cin_i, idx<=0, prev<=0, and the accumulator is cleared.
- RUN, each cycle:
  - slice_a_o=a_sh[0], slice_b_o=b_sh[0], slice_cin_o=carry, slice_sel_o=op_q; all slice inputs come straight from flops.
  - bit = slice_f_i when op_q[3]==0.
  - shift-right (op_q[3:2]=10): bit=a_sh[1]; 0 at idx==WIDTH-1.
  - shift-left (op_q[3:2]=11): bit=prev.
  - Updates: acc<={bit,acc[WIDTH-1:1]}, a_sh>>=1 (zero fill), b_sh>>=1, prev<=a_sh[0], carry<=slice_cout_i, idx++.
- DONE cycle:
  - result_o<=acc.
  - cout_o = carry for arithmetic (00); original A[0] for shr (latched at accept); original A[WIDTH-1] for shl, which equals prev at DONE; 0 for logic (01).
  - done_o=1 for exactly this cycle.
- Latency: accept at edge N; done_o high during cycle N+WIDTH+1. Throughput is one op per WIDTH+2 cycles.
- start_i while busy, in DONE, or deasserted is ignored, with no effect on the operation in flight. Operand inputs are don't-care outside the accept cycle.
- Reset mid-RUN aborts immediately. No done_o is issued and result_o returns to 0.
- slice_sel_o holds op_q in IDLE after an operation. Slice outputs are ignored outside RUN.
- idx never exceeds WIDTH-1 and does not wrap.

Decomposition:
- Package alu_pkg: OP_* 4-bit constants (OP_ADD=4'b0001 meaning A+B+cin, OP_AND=4'b0100, OP_SHR=4'b1000, OP_SHL=4'b1100), state_e enum {IDLE,RUN,DONE}, and SEL_ARITH/SEL_LOGIC/SEL_SHR/SEL_SHL 2-bit group codes.
- No sub-module. The slice is instantiated alongside this block at the next level up, not inside it.

Test Plan:
- Reset: hold rst_ni=0 with start_i=1 -> ready_o=1, done_o=0, result_o=0; no accept occurs until release.
- OP_ADD, a=0xFFFFFFFF, b=0x00000001, cin=0 -> done_o in cycle 33 after accept, result_o=0x00000000, cout_o=1; busy_o high for exactly 32 cycles.
- OP_AND, a=0xF0F0A5A5, b=0xFF00FF00 -> result_o=0xF000A500, cout_o=0.
- OP_SHR a=0x80000001 -> 0x40000000, cout_o=1; OP_SHL a=0x80000001 -> 0x00000002, cout_o=1.
- start_i pulsed mid-RUN with different operands -> ignored; the first op's result is unchanged; back-to-back accept is possible on the cycle after done_o.
- rst_ni low at idx=10 of an OP_ADD -> no done_o; outputs return to reset values; a fresh op afterwards completes correctly.
